// File: rtl/count7_pkg.sv
// rtl/count7_pkg.sv - shared types and defaults for the 7-bit counter family
package count7_pkg;

    localparam int CNT_W = 7;

    typedef logic [CNT_W-1:0] count_t;

    localparam count_t DEFAULT_PERIOD  = 7'h7F;
    localparam count_t DEFAULT_COMPARE = 7'h40;

endpackage

// File: rtl/count7_edge_det.sv
// rtl/count7_edge_det.sv - rising-edge detector with synchronous reset
module count7_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic din_q;

    // Remember last cycle's level so a rise is seen for exactly one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/count7_up.sv
// rtl/count7_up.sv - 7-bit up-counter with tc/cmp flags; capture path built when COUNT7_UP_CAPTURE_EN is defined
module count7_up
    import count7_pkg::*;
#(
    parameter count_t PERIOD        = DEFAULT_PERIOD,
    parameter count_t COMPARE       = DEFAULT_COMPARE,
    parameter logic   ENABLE_SIGNAL = 1'b0,
    parameter logic   LOAD_SIGNAL   = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic         capture,
    input  logic         cap_ack,
    output logic [6:0]   cnt,
    output logic         tc,
    output logic         cmp,
    output logic [6:0]   cap_data,
    output logic         cap_valid,
    output logic         cap_ovf
);

    logic en_eff;
    logic ld_eff;
    logic at_period;

    // Ports that are not configured in are tied off here rather than at each use.
    assign en_eff    = ENABLE_SIGNAL ? en : 1'b1;
    assign ld_eff    = LOAD_SIGNAL ? load : 1'b0;
    assign at_period = (cnt == PERIOD);

    // Count register: reset beats load, load beats count, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (ld_eff) begin
            cnt <= '0;
        end else if (en_eff) begin
            cnt <= at_period ? count_t'(0) : cnt + count_t'(1);
        end
    end

    assign tc  = at_period & en_eff;
    assign cmp = (cnt >= COMPARE);

`ifdef COUNT7_UP_CAPTURE_EN

    logic cap_evt;

    count7_edge_det u_cap_edge (
        .clock (clock),
        .reset (reset),
        .din   (capture),
        .pulse (cap_evt)
    );

    // Capture holding register: a new edge always latches the current count;
    // overrun only when the consumer neither took nor is taking the old value.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_data  <= '0;
            cap_valid <= 1'b0;
            cap_ovf   <= 1'b0;
        end else if (cap_evt) begin
            cap_data  <= cnt;
            cap_valid <= 1'b1;
            if (cap_valid && !cap_ack) begin
                cap_ovf <= 1'b1;
            end
        end else if (cap_ack) begin
            cap_valid <= 1'b0;
        end
    end

`else

    logic unused_cap_inputs;

    assign unused_cap_inputs = capture ^ cap_ack;
    assign cap_data          = '0;
    assign cap_valid         = 1'b0;
    assign cap_ovf           = 1'b0;

`endif

endmodule

// File: tb/tb_count7_up.sv
// tb/tb_count7_up.sv - scoreboard bench for count7_up across several parameter sets
module tb_count7_up;

`ifdef COUNT7_UP_CAPTURE_EN
    localparam bit CAP_ON = 1'b1;
`else
    localparam bit CAP_ON = 1'b0;
`endif

    typedef struct {
        int         id;
        logic [6:0] cnt;
        logic       tc;
        logic       cmp;
        logic [6:0] cd;
        logic       cv;
        logic       co;
        string      name;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       cap;
        logic       ack;
        logic [6:0] ecnt;
        logic [6:0] ecd;
        logic       ecv;
        logic       eco;
    } row_t;

    typedef struct packed {
        logic       en;
        logic       ld;
        logic [6:0] ecnt;
        logic       etc;
        logic       ecmp;
    } en_row_t;

    // Capture sequence on the free-running default counter, cnt 16..32.
    localparam row_t SEG1 [0:16] = '{
        '{1'b0, 1'b0, 1'b0, 7'd16, 7'd0,  1'b0, 1'b0},
        '{1'b0, 1'b1, 1'b0, 7'd17, 7'd0,  1'b0, 1'b0},
        '{1'b0, 1'b1, 1'b0, 7'd18, 7'd17, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b1, 7'd19, 7'd17, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 7'd20, 7'd17, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd21, 7'd17, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd22, 7'd17, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd23, 7'd17, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd24, 7'd17, 1'b0, 1'b0},
        '{1'b0, 1'b1, 1'b0, 7'd25, 7'd17, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd26, 7'd25, 1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd27, 7'd25, 1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd28, 7'd25, 1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd29, 7'd25, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 7'd30, 7'd25, 1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b1, 7'd31, 7'd30, 1'b1, 1'b1},
        '{1'b0, 1'b0, 1'b0, 7'd32, 7'd30, 1'b0, 1'b1}
    };

    // Pending capture at cnt 88, reset at 90, then capture with same-cycle ack.
    localparam row_t SEG2 [0:9] = '{
        '{1'b0, 1'b1, 1'b0, 7'd88, 7'd30, 1'b0, 1'b1},
        '{1'b0, 1'b0, 1'b0, 7'd89, 7'd88, 1'b1, 1'b1},
        '{1'b1, 1'b0, 1'b0, 7'd90, 7'd88, 1'b1, 1'b1},
        '{1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 1'b0},
        '{1'b0, 1'b1, 1'b0, 7'd1,  7'd0,  1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd2,  7'd1,  1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b1, 7'd3,  7'd1,  1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd4,  7'd3,  1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b1, 7'd5,  7'd3,  1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b0, 7'd6,  7'd3,  1'b0, 1'b0}
    };

    // PERIOD=5, COMPARE=3, en and load both live.
    localparam en_row_t U1_ROWS [0:14] = '{
        '{1'b1, 1'b0, 7'd0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 7'd1, 1'b0, 1'b0},
        '{1'b1, 1'b0, 7'd1, 1'b0, 1'b0},
        '{1'b1, 1'b0, 7'd2, 1'b0, 1'b0},
        '{1'b1, 1'b0, 7'd3, 1'b0, 1'b1},
        '{1'b1, 1'b0, 7'd4, 1'b0, 1'b1},
        '{1'b0, 1'b0, 7'd5, 1'b0, 1'b1},
        '{1'b1, 1'b0, 7'd5, 1'b1, 1'b1},
        '{1'b1, 1'b0, 7'd0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 7'd1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 7'd2, 1'b0, 1'b0},
        '{1'b0, 1'b0, 7'd0, 1'b0, 1'b0},
        '{1'b1, 1'b1, 7'd0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 7'd0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 7'd1, 1'b0, 1'b0}
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, en0, ld0, capt0, ack0;
    logic rst1, en1, ld1;
    logic rst2, en2;
    logic rst3, en3, ld3;

    logic [6:0] cnt0, cnt1, cnt2, cnt3;
    logic       tc0, tc1, tc2, tc3;
    logic       cmp0, cmp1, cmp2, cmp3;
    logic [6:0] cd0, cd1, cd2, cd3;
    logic       cv0, cv1, cv2, cv3;
    logic       co0, co1, co2, co3;

    count7_up #(.PERIOD(7'h7F), .COMPARE(7'h40), .ENABLE_SIGNAL(1'b0), .LOAD_SIGNAL(1'b0)) u0 (
        .clock(clk), .reset(rst0), .en(en0), .load(ld0), .capture(capt0), .cap_ack(ack0),
        .cnt(cnt0), .tc(tc0), .cmp(cmp0), .cap_data(cd0), .cap_valid(cv0), .cap_ovf(co0));

    count7_up #(.PERIOD(7'd5), .COMPARE(7'd3), .ENABLE_SIGNAL(1'b1), .LOAD_SIGNAL(1'b1)) u1 (
        .clock(clk), .reset(rst1), .en(en1), .load(ld1), .capture(1'b0), .cap_ack(1'b0),
        .cnt(cnt1), .tc(tc1), .cmp(cmp1), .cap_data(cd1), .cap_valid(cv1), .cap_ovf(co1));

    count7_up #(.PERIOD(7'd0), .COMPARE(7'h40), .ENABLE_SIGNAL(1'b1), .LOAD_SIGNAL(1'b0)) u2 (
        .clock(clk), .reset(rst2), .en(en2), .load(1'b0), .capture(1'b0), .cap_ack(1'b0),
        .cnt(cnt2), .tc(tc2), .cmp(cmp2), .cap_data(cd2), .cap_valid(cv2), .cap_ovf(co2));

    count7_up #(.PERIOD(7'h7F), .COMPARE(7'h40), .ENABLE_SIGNAL(1'b1), .LOAD_SIGNAL(1'b1)) u3 (
        .clock(clk), .reset(rst3), .en(en3), .load(ld3), .capture(1'b0), .cap_ack(1'b0),
        .cnt(cnt3), .tc(tc3), .cmp(cmp3), .cap_data(cd3), .cap_valid(cv3), .cap_ovf(co3));

    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int id, input logic [6:0] c, input logic t, input logic m,
                              input logic [6:0] d, input logic v, input logic o, input string nm);
        exp_t e;
        e.id = id; e.cnt = c; e.tc = t; e.cmp = m;
        e.cd = CAP_ON ? d : 7'd0;
        e.cv = CAP_ON ? v : 1'b0;
        e.co = CAP_ON ? o : 1'b0;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic fill0(input int from, input int upto, input logic [6:0] d, input logic v, input logic o);
        capt0 = 1'b0;
        ack0  = 1'b0;
        for (int c = from; c <= upto; c++) begin
            expect_out(0, 7'(c), 1'b0, (c >= 64), d, v, o, "u0_fill");
            tick();
        end
    endtask

    // Monitor: every cycle, drain what the stimulus predicted and compare.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t       e;
            logic [6:0] a_cnt, a_cd;
            logic       a_tc, a_cmp, a_cv, a_co;
            e = sb_q.pop_front();
            case (e.id)
                0:       begin a_cnt = cnt0; a_tc = tc0; a_cmp = cmp0; a_cd = cd0; a_cv = cv0; a_co = co0; end
                1:       begin a_cnt = cnt1; a_tc = tc1; a_cmp = cmp1; a_cd = cd1; a_cv = cv1; a_co = co1; end
                2:       begin a_cnt = cnt2; a_tc = tc2; a_cmp = cmp2; a_cd = cd2; a_cv = cv2; a_co = co2; end
                default: begin a_cnt = cnt3; a_tc = tc3; a_cmp = cmp3; a_cd = cd3; a_cv = cv3; a_co = co3; end
            endcase
            checks++;
            if ({a_cnt, a_tc, a_cmp, a_cd, a_cv, a_co} !== {e.cnt, e.tc, e.cmp, e.cd, e.cv, e.co}) begin
                errors++;
                $display("FAIL %s t=%0t got cnt=%0d tc=%b cmp=%b cap_data=%0d cap_valid=%b cap_ovf=%b expected cnt=%0d tc=%b cmp=%b cap_data=%0d cap_valid=%b cap_ovf=%b",
                         e.name, $time, a_cnt, a_tc, a_cmp, a_cd, a_cv, a_co,
                         e.cnt, e.tc, e.cmp, e.cd, e.cv, e.co);
            end
        end
    end

    initial begin
        rst0 = 1'b1; en0 = 1'b0; ld0 = 1'b0; capt0 = 1'b0; ack0 = 1'b0;
        rst1 = 1'b1; en1 = 1'b0; ld1 = 1'b0;
        rst2 = 1'b1; en2 = 1'b0;
        rst3 = 1'b1; en3 = 1'b0; ld3 = 1'b0;
        repeat (3) tick();

        // Reset state of every instance.
        expect_out(0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "u0_reset");
        expect_out(1, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "u1_reset");
        expect_out(2, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "u2_reset");
        expect_out(3, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "u3_reset");

        // u0 ignores en and load: hold them at values that would otherwise stop/clear it.
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        en0  = 1'b0; ld0 = 1'b1;

        // Full wrap: 0..127, tc only at 127, then back to 0, 1.
        for (int i = 0; i < 130; i++) begin
            expect_out(0, 7'(i % 128), (i == 127), ((i % 128) >= 64), 7'd0, 1'b0, 1'b0, "u0_wrap");
            tick();
        end
        fill0(2, 15, 7'd0, 1'b0, 1'b0);

        for (int k = 0; k <= 16; k++) begin
            rst0 = SEG1[k].rst; capt0 = SEG1[k].cap; ack0 = SEG1[k].ack;
            expect_out(0, SEG1[k].ecnt, 1'b0, (SEG1[k].ecnt >= 7'd64), SEG1[k].ecd, SEG1[k].ecv, SEG1[k].eco, "u0_cap1");
            tick();
        end
        fill0(33, 87, 7'd30, 1'b0, 1'b1);

        for (int k = 0; k <= 9; k++) begin
            rst0 = SEG2[k].rst; capt0 = SEG2[k].cap; ack0 = SEG2[k].ack;
            expect_out(0, SEG2[k].ecnt, 1'b0, (SEG2[k].ecnt >= 7'd64), SEG2[k].ecd, SEG2[k].ecv, SEG2[k].eco, "u0_cap2");
            tick();
        end
        capt0 = 1'b0; ack0 = 1'b0;

        // u1: en gating, tc qualified by en, cmp threshold, load priority.
        for (int k = 0; k <= 14; k++) begin
            en1 = U1_ROWS[k].en; ld1 = U1_ROWS[k].ld;
            expect_out(1, U1_ROWS[k].ecnt, U1_ROWS[k].etc, U1_ROWS[k].ecmp, 7'd0, 1'b0, 1'b0, "u1_en_ld");
            tick();
        end
        en1 = 1'b0; ld1 = 1'b0;

        // u2: PERIOD=0 keeps cnt at 0 and tc mirrors en.
        en2 = 1'b0; expect_out(2, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "u2_p0_en0"); tick();
        en2 = 1'b1; expect_out(2, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, "u2_p0_en1"); tick();
        en2 = 1'b1; expect_out(2, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, "u2_p0_en1b"); tick();
        en2 = 1'b0; expect_out(2, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "u2_p0_en0b"); tick();

        // u3: count to 40 with en=1, load there clears to 0, counting resumes.
        en3 = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            ld3 = (i == 40);
            expect_out(3, 7'(i), 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "u3_count");
            tick();
        end
        ld3 = 1'b0;
        expect_out(3, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "u3_load40"); tick();
        expect_out(3, 7'd1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "u3_resume"); tick();

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
